// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C master sequencer: optional START, 8 data bits, ACK bit, optional STOP.
// SCL/SDA levels are registered and change only on phase boundaries of a CLK_DIV prescaler.
module i2c_byte_ctrl #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_start_i,
    input  logic       cmd_stop_i,
    input  logic       cmd_read_i,
    input  logic       cmd_nack_i,
    input  logic [7:0] tx_data_i,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] rx_data_o,
    output logic       ack_o,
    output logic       scl_o,
    output logic       sda_oe_o,
    input  logic       sda_i
);

    localparam int unsigned PW = 16;
    localparam logic [PW-1:0] PRESC_LOAD = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          stop_q, stop_d;
    logic          read_q, read_d;
    logic          nack_q, nack_d;
    logic          held_q, held_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    rx_q, rx_d;
    logic          ack_q, ack_d;
    logic          scl_q, scl_d;
    logic          sda_oe_q, sda_oe_d;
    logic          tick;
    logic          enter;

    assign tick = (presc_q == '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            presc_q   <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            stop_q    <= 1'b0;
            read_q    <= 1'b0;
            nack_q    <= 1'b0;
            held_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rx_q      <= 8'd0;
            ack_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            presc_q   <= presc_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            read_q    <= read_d;
            nack_q    <= nack_d;
            held_q    <= held_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rx_q      <= rx_d;
            ack_q     <= ack_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    // Next-state logic and pad levels for the phase being entered
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        presc_d   = presc_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        read_d    = read_q;
        nack_d    = nack_q;
        held_d    = held_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rx_d      = rx_q;
        ack_d     = ack_q;
        scl_d     = scl_q;
        sda_oe_d  = sda_oe_q;
        enter     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    stop_d  = cmd_stop_i;
                    read_d  = cmd_read_i;
                    nack_d  = cmd_nack_i;
                    shift_d = tx_data_i;
                    if (!cmd_start_i && !held_q) begin
                        // No START and no owned bus: reject without touching the pads
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d   = cmd_start_i ? S_START : S_BIT;
                        phase_d   = 2'd0;
                        bit_cnt_d = 3'd0;
                        presc_d   = PRESC_LOAD;
                        ready_d   = 1'b0;
                        enter     = 1'b1;
                    end
                end
            end
            S_START, S_BIT, S_ACK, S_STOP: begin
                if (!tick) begin
                    presc_d = presc_q - PW'(1);
                end else if (phase_q != 2'd3) begin
                    presc_d = PRESC_LOAD;
                    phase_d = phase_q + 2'd1;
                    enter   = 1'b1;
                    if (phase_q == 2'd2) begin
                        if (state_q == S_BIT && read_q) begin
                            shift_d = {shift_q[6:0], sda_i};
                        end
                        if (state_q == S_ACK && !read_q) begin
                            ack_d = ~sda_i;
                        end
                    end
                end else begin
                    presc_d = PRESC_LOAD;
                    phase_d = 2'd0;
                    enter   = 1'b1;
                    unique case (state_q)
                        S_START: begin
                            held_d    = 1'b1;
                            state_d   = S_BIT;
                            bit_cnt_d = 3'd0;
                        end
                        S_BIT: begin
                            if (!read_q) begin
                                shift_d = {shift_q[6:0], 1'b0};
                            end
                            if (bit_cnt_q == 3'd7) begin
                                state_d = S_ACK;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 3'd1;
                            end
                        end
                        S_ACK: begin
                            if (stop_q) begin
                                state_d = S_STOP;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end
                        S_STOP: begin
                            held_d  = 1'b0;
                            state_d = S_IDLE;
                        end
                        default: ;
                    endcase
                    if (state_d == S_IDLE) begin
                        // Finish: pads keep their last level, bus stays held if no STOP
                        enter   = 1'b0;
                        presc_d = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        if (read_q) begin
                            rx_d = shift_q;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (enter) begin
            unique case (state_d)
                S_START: begin
                    scl_d    = (phase_d == 2'd0) ? ~held_q : (phase_d != 2'd3);
                    sda_oe_d = phase_d[1];
                end
                S_BIT: begin
                    scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                    sda_oe_d = read_d ? 1'b0 : ~shift_d[7];
                end
                S_ACK: begin
                    scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                    sda_oe_d = read_d ? ~nack_d : 1'b0;
                end
                S_STOP: begin
                    scl_d    = (phase_d != 2'd0);
                    sda_oe_d = (phase_d != 2'd3);
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign rx_data_o   = rx_q;
    assign ack_o       = ack_q;
    assign scl_o       = scl_q;
    assign sda_oe_o    = sda_oe_q;

endmodule

// File: doc/i2c_byte_ctrl.md
Name: i2c_byte_ctrl

Overview:
Byte-level I2C master sequencer that turns one command into SCL/SDA activity at the I2C bit rate. A command is an optional START, 8 data bits, an ACK bit, then an optional STOP. The block sits behind the Wishbone slave register file, which issues commands and collects results. It owns the shift register and the SCL timing. The pads are open-drain, driven externally from scl_o and sda_oe_o.

Parameters:
CLK_DIV, 125, clk_i cycles per quarter SCL period (phase); legal range 2..65535; SCL period = 4*CLK_DIV.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  block idle, command accepted when cmd_valid_i&&cmd_ready_o
cmd_start_i  in  1  issue (repeated) START before the byte
cmd_stop_i  in  1  issue STOP after the ACK bit
cmd_read_i  in  1  1 = read byte, 0 = write tx_data_i
cmd_nack_i  in  1  read only: ACK bit value master sends (1 = NACK)
tx_data_i  in  8  write byte, sent MSB first
done_o  out  1  one-cycle pulse, command finished
err_o  out  1  valid with done_o: command rejected
rx_data_o  out  8  read byte, valid from done_o until next done_o
ack_o  out  1  write only: 1 = slave acknowledged (sampled SDA low); valid with done_o
scl_o  out  1  SCL level (1 = released)
sda_oe_o  out  1  1 = pull SDA low, 0 = release
sda_i  in  1  sampled SDA pad level

Behaviour:
- Reset values (synchronous, also mid-operation): cmd_ready_o=1, done_o=0, err_o=0, rx_data_o=0, ack_o=0, scl_o=1, sda_oe_o=0, bus_held=0, prescaler=0, state IDLE. Reset aborts any transfer; no STOP is generated.
- Prescaler: loaded with CLK_DIV-1 on entry to each phase and counts down. A tick occurs at 0 and advances the phase (0..3). Each phase lasts exactly CLK_DIV cycles.
- States: IDLE, START, BIT, ACK, STOP.
- IDLE:
  - Accept cycle: latch the flags and tx_data_i into the shift register. cmd_ready_o falls in the next cycle.
  - If cmd_start_i=0 and bus_held=0: perform no SCL/SDA activity. Next cycle: done_o=1, err_o=1, cmd_ready_o=1.
  - Otherwise go to START if cmd_start_i=1, else to BIT.
- Phase encodings (scl, sda_oe), phases 0..3:
  - START: (H-or-L, 0), (1,0), (1,1), (0,1). Phase 0 SCL is 0 if bus_held (repeated start), else 1. Sets bus_held=1.
  - BIT/ACK: (0,d), (1,d), (1,d), (0,d). d = ~bit for driven bits, 0 when released.
  - STOP: (0,1), (1,1), (1,1), (1,0). Clears bus_held.
- BIT runs 8 times, MSB first.
  - Write: d from shift[7].
  - Read: released; sda_i is sampled into shift LSB at the tick ending phase 2.
- ACK:
  - Write: released; ack_o <= ~sda_i, sampled at the tick ending phase 2.
  - Read: drives cmd_nack_i (1 = released).
- After ACK: go to STOP if cmd_stop_i, else finish.
- Finish: the cycle after the last phase-3 tick, state is IDLE with done_o=1, err_o=0, cmd_ready_o=1. rx_data_o updates in that same cycle.
- Without STOP the bus is held with scl_o=0. sda_oe_o keeps its last ACK-phase value until the next command's phase 0.
- Latency: accept to done = 1 + 4*CLK_DIV*(9 + start + stop) cycles.
- cmd_valid_i while busy is ignored; no queuing.
- No clock stretching or arbitration detection: SCL is driven purely by timing.

Test Plan:
- CLK_DIV=4, write 0xA5, start=1, stop=1, sda_i low during ACK. Required: SCL falling edges show SDA bits 1,0,1,0,0,1,0,1; ack_o=1; done_o exactly 177 cycles after accept; final scl_o=1, sda_oe_o=0.
- Same write with sda_i high during ACK. Required: ack_o=0, err_o=0, STOP still generated.
- Read with start=1, stop=1, nack=1, sda_i modelling slave byte 0x3C. Required: rx_data_o=0x3C; sda_oe_o=0 through ACK bit; done_o at cycle 177.
- Command start=0 after reset. Required: done_o and err_o pulse 1 cycle after accept; scl_o stays 1; no edges.
- Write 0x50 with start=1, stop=0, then read with start=1, stop=1. Required:
  - scl_o held 0 between commands.
  - Repeated START: SDA goes high while SCL low, then falls while SCL high.
  - Both done_o pulses have err_o=0.
- rst_i asserted at bit 4 of a write. Required: next cycle scl_o=1, sda_oe_o=0, cmd_ready_o=1. A following start=0 command is rejected (err_o=1).
